// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle RV32 datapath: Moore state outputs plus
// combinational ALU-control and immediate-format decoders.
module multicycle_control_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_reg;
    state_t     state_next;

    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic       mem_write_st;
    logic       ir_write_st;
    logic       reg_write_st;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR; op[5] separates them.
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore outputs of state
    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        alu_op       = 2'b00;
        AdrSrc       = 1'b0;
        mem_write_st = 1'b0;
        ir_write_st  = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        reg_write_st = 1'b0;
        illegal      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write_st = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                pc_update   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                reg_write_st = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                mem_write_st = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                reg_write_st = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_HALT: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    // Write enables are gated by rst_n so nothing writes while reset is held.
    assign PCWrite  = rst_n & (pc_update | (branch & zero));
    assign IRWrite  = rst_n & ir_write_st;
    assign MemWrite = rst_n & mem_write_st;
    assign RegWrite = rst_n & reg_write_st;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

endmodule
